// File: rtl/gf_prod_acc.sv
// GF(2^deg) frame product: a FIFO absorbs the element burst while a bit-serial
// MSB-first multiplier folds each element into the running product acc.
module gf_prod_acc #(
    parameter int WIDTH   = 5,
    parameter int MAX_LEN = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic [2:0]       deg,
    input  logic [WIDTH:0]   poly,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_err,
    output logic             busy
);
    localparam int PTR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int CNT_W = $clog2(MAX_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_LEN);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_LEN - 1);

    typedef enum logic [1:0] {IDLE, ACC, DRAIN, DONE} state_e;

    state_e           state_q, state_d;
    logic [2:0]       deg_q;
    logic [WIDTH:0]   poly_q;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             err_q;
    logic [CNT_W-1:0] frameCnt_q;
    logic [CNT_W-1:0] fifoCnt_q;
    logic [PTR_W-1:0] wrPtr_q, rdPtr_q;
    logic [WIDTH-1:0] fifoMem [MAX_LEN];
    logic             mulBusy_q;
    logic [2:0]       bitIdx_q;
    logic [WIDTH-1:0] b_q, r_q;

    logic             startFrame, acceptWin, pushEn, dropEn, popEn, fifoEmpty;
    logic [WIDTH-1:0] fifoHead, stepR, stepOut;
    logic             stepBit;

    // One shift-and-add step; r stays below x^deg so a single conditional reduction suffices.
    function automatic logic [WIDTH-1:0] mulStep(
        input logic [WIDTH-1:0] r,
        input logic             b,
        input logic [WIDTH-1:0] a,
        input logic [2:0]       d,
        input logic [WIDTH:0]   p
    );
        logic [WIDTH:0] t;
        t = {r, 1'b0} ^ (b ? {1'b0, a} : '0);
        if (t[d]) t = t ^ p;
        return t[WIDTH-1:0];
    endfunction

    function automatic logic [PTR_W-1:0] ptrNext(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign startFrame = (state_q == IDLE) && in_valid;
    assign acceptWin  = ((state_q == IDLE) || (state_q == ACC)) && in_valid;
    assign pushEn     = acceptWin && (frameCnt_q < CNT_MAX);
    assign dropEn     = acceptWin && (frameCnt_q >= CNT_MAX);
    assign fifoEmpty  = (fifoCnt_q == '0);
    assign popEn      = !mulBusy_q && !fifoEmpty;
    assign fifoHead   = fifoMem[rdPtr_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = ACC;
            ACC:     if (!in_valid) state_d = DRAIN;
            DRAIN:   if (fifoEmpty && !mulBusy_q) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state_q == DONE);
        out_data  = (state_q == DONE) ? acc_q : '0;
        out_err   = (state_q == DONE) ? err_q : 1'b0;
        busy      = (state_q != IDLE);
    end

    // A pop performs the first (MSB) step immediately, so an element takes exactly deg edges.
    always_comb begin
        stepR   = mulBusy_q ? r_q : '0;
        stepBit = mulBusy_q ? b_q[bitIdx_q] : fifoHead[deg_q - 3'd1];
        stepOut = mulStep(stepR, stepBit, acc_q, deg_q, poly_q);
        acc_d   = acc_q;
        if (startFrame)
            acc_d = WIDTH'(1);
        else if (mulBusy_q && (bitIdx_q == 3'd0))
            acc_d = stepOut;
    end

    always_ff @(posedge clk) begin
        if (pushEn) fifoMem[wrPtr_q] <= in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deg_q      <= 3'd2;
            poly_q     <= '0;
            acc_q      <= WIDTH'(1);
            err_q      <= 1'b0;
            frameCnt_q <= '0;
            fifoCnt_q  <= '0;
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            mulBusy_q  <= 1'b0;
            bitIdx_q   <= 3'd0;
            b_q        <= '0;
            r_q        <= '0;
        end else begin
            if (startFrame) begin
                deg_q  <= deg;
                poly_q <= poly;
                err_q  <= 1'b0;
            end else if (dropEn) begin
                err_q  <= 1'b1;
            end
            acc_q <= acc_d;

            if (state_q == DONE)
                frameCnt_q <= '0;
            else if (pushEn)
                frameCnt_q <= frameCnt_q + CNT_W'(1);

            if (pushEn) wrPtr_q <= ptrNext(wrPtr_q);
            if (popEn)  rdPtr_q <= ptrNext(rdPtr_q);
            case ({pushEn, popEn})
                2'b10:   fifoCnt_q <= fifoCnt_q + CNT_W'(1);
                2'b01:   fifoCnt_q <= fifoCnt_q - CNT_W'(1);
                default: fifoCnt_q <= fifoCnt_q;
            endcase

            if (popEn) begin
                mulBusy_q <= 1'b1;
                b_q       <= fifoHead;
                r_q       <= stepOut;
                bitIdx_q  <= deg_q - 3'd2;
            end else if (mulBusy_q) begin
                r_q      <= stepOut;
                bitIdx_q <= bitIdx_q - 3'd1;
                if (bitIdx_q == 3'd0) mulBusy_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_gf_prod_acc.sv
// Self-checking bench for gf_prod_acc: directed field cases plus randomized frames
// checked against a carry-less multiply / polynomial-reduce reference model.
module tb_gf_prod_acc;
    localparam int WIDTH   = 5;
    localparam int MAX_LEN = 8;
    localparam int BUDGET  = 400;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic [2:0]       deg;
    logic [WIDTH:0]   poly;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_err;
    logic             busy;

    int total = 0;
    int bad   = 0;
    int frameData [16];

    gf_prod_acc #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .deg      (deg),
        .poly     (poly),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_err  (out_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Reference: full carry-less product, then reduce from the top degree downwards.
    function automatic int gfMul(input int a, input int b, input int dg, input int pl);
        int prod = 0;
        for (int i = 0; i < dg; i++)
            if (((b >> i) & 1) == 1) prod = prod ^ (a << i);
        for (int i = 2 * dg - 2; i >= dg; i--)
            if (((prod >> i) & 1) == 1) prod = prod ^ (pl << (i - dg));
        return prod;
    endfunction

    function automatic int frameProduct(input int n, input int dg, input int pl);
        int p = 1;
        int m = (n < MAX_LEN) ? n : MAX_LEN;
        for (int k = 0; k < m; k++)
            p = gfMul(p, frameData[k] & ((1 << dg) - 1), dg, pl);
        return p;
    endfunction

    // Elements issue every deg cycles from edge 1; DONE also cannot precede the end of the frame.
    function automatic int expectedCycle(input int n, input int dg);
        int m = (n < MAX_LEN) ? n : MAX_LEN;
        int a = m * dg;
        return ((a > n) ? a : n) + 1;
    endfunction

    function automatic int pickPoly(input int dg);
        int p3 [2] = '{11, 13};
        int p4 [3] = '{19, 25, 31};
        int p5 [6] = '{37, 41, 47, 55, 59, 61};
        case (dg)
            2:       return 7;
            3:       return p3[$urandom_range(0, 1)];
            4:       return p4[$urandom_range(0, 2)];
            default: return p5[$urandom_range(0, 5)];
        endcase
    endfunction

    // Drives one contiguous frame from frameData, optional junk in_valid pulses afterwards,
    // and captures the result plus the cycle after it (edge index of the first element = 0).
    task automatic applyStimulus(input int dg, input int pl, input int n,
                                 input int junkStart, input int junkLen,
                                 output int vCycle, output logic [WIDTH-1:0] vData,
                                 output logic vErr, output int glitches,
                                 output logic postValid, output logic postBusy);
        vCycle   = -1;
        vData    = 'x;
        vErr     = 1'bx;
        glitches = 0;
        for (int cyc = 0; cyc < BUDGET && vCycle < 0; cyc++) begin
            @(negedge clk);
            if (cyc < n) begin
                in_valid = 1'b1;
                in_data  = WIDTH'(frameData[cyc]);
            end else begin
                in_valid = (junkLen > 0) && (cyc >= junkStart) && (cyc < junkStart + junkLen);
                in_data  = WIDTH'($urandom);
            end
            deg  = (cyc == 0) ? 3'(dg) : 3'($urandom);
            poly = (cyc == 0) ? (WIDTH+1)'(pl) : (WIDTH+1)'($urandom);
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) begin
                vCycle = cyc;
                vData  = out_data;
                vErr   = out_err;
            end else if (out_data !== '0) begin
                glitches++;
            end
            if (busy !== 1'b1) glitches++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        postValid = out_valid;
        postBusy  = busy;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; deg = 3'd3; poly = 6'd11;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
        total++; if (out_data !== '0) begin bad++; $display("FAIL reset out_data: got %0d want 0", out_data); end
        total++; if (out_err !== 1'b0) begin bad++; $display("FAIL reset out_err: got %b want 0", out_err); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset busy: got %b want 0", busy); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int c, g; logic [WIDTH-1:0] d; logic e, pv, pb;
        frameData[0] = 2; frameData[1] = 3;
        applyStimulus(3, 11, 2, 0, 0, c, d, e, g, pv, pb);
        total++; if (d !== 5'd6) begin bad++; $display("FAIL basic_2x3 data: got %0d want 6", d); end
        total++; if (e !== 1'b0) begin bad++; $display("FAIL basic_2x3 err: got %b want 0", e); end
        total++; if (c !== 7) begin bad++; $display("FAIL basic_2x3 cycle: got %0d want 7", c); end
        frameData[0] = 2; frameData[1] = 5;
        applyStimulus(3, 11, 2, 0, 0, c, d, e, g, pv, pb);
        total++; if (d !== 5'd1) begin bad++; $display("FAIL inverse_pair data: got %0d want 1", d); end
        total++; if (g !== 0) begin bad++; $display("FAIL inverse_pair glitches: got %0d want 0", g); end
    endtask

    task automatic test_burst();
        int c, g; logic [WIDTH-1:0] d; logic e, pv, pb;
        for (int k = 0; k < 5; k++) frameData[k] = 2;
        applyStimulus(5, 37, 5, 0, 0, c, d, e, g, pv, pb);
        total++; if (d !== 5'd5) begin bad++; $display("FAIL burst_x5 data: got %0d want 5", d); end
        total++; if (c !== 26) begin bad++; $display("FAIL burst_x5 cycle: got %0d want 26", c); end
    endtask

    task automatic test_single_latency();
        int c, g; logic [WIDTH-1:0] d; logic e, pv, pb;
        frameData[0] = 5;
        applyStimulus(3, 11, 1, 0, 0, c, d, e, g, pv, pb);
        total++; if (c !== 4) begin bad++; $display("FAIL single cycle: got %0d want 4", c); end
        total++; if (d !== 5'd5) begin bad++; $display("FAIL single data: got %0d want 5", d); end
        total++; if (pv !== 1'b0) begin bad++; $display("FAIL single pulse_width: got %b want 0", pv); end
        total++; if (pb !== 1'b0) begin bad++; $display("FAIL single busy_after: got %b want 0", pb); end
        total++; if (g !== 0) begin bad++; $display("FAIL single glitches: got %0d want 0", g); end
    endtask

    task automatic test_overflow();
        int c, g; logic [WIDTH-1:0] d; logic e, pv, pb;
        for (int k = 0; k < 9; k++) frameData[k] = 2;
        applyStimulus(3, 11, 9, 0, 0, c, d, e, g, pv, pb);
        // Only the first eight elements count: x^8 = x since x^7 = 1 in GF(8).
        total++; if (d !== 5'd2) begin bad++; $display("FAIL overflow data: got %0d want 2", d); end
        total++; if (e !== 1'b1) begin bad++; $display("FAIL overflow err: got %b want 1", e); end
        total++; if (c !== 25) begin bad++; $display("FAIL overflow cycle: got %0d want 25", c); end
        frameData[0] = 3;
        applyStimulus(3, 11, 1, 0, 0, c, d, e, g, pv, pb);
        total++; if (d !== 5'd3) begin bad++; $display("FAIL after_overflow data: got %0d want 3", d); end
        total++; if (e !== 1'b0) begin bad++; $display("FAIL after_overflow err: got %b want 0", e); end
    endtask

    task automatic test_reset_mid_frame();
        int c, g, seen; logic [WIDTH-1:0] d; logic e, pv, pb;
        @(negedge clk); in_valid = 1'b1; in_data = 5'd2; deg = 3'd3; poly = 6'd11;
        @(negedge clk); in_data = 5'd3;
        @(negedge clk); in_data = 5'd4;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL midreset busy_before: got %b want 1", busy); end
        #2 rst = 1'b1;
        #1;
        total++; if ({out_valid, out_data, out_err, busy} !== '0) begin
            bad++; $display("FAIL midreset outputs: got %b want 0", {out_valid, out_data, out_err, busy});
        end
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        seen = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0 || busy !== 1'b0) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL midreset stray_output: got %0d cycles want 0", seen); end
        frameData[0] = 2; frameData[1] = 5;
        applyStimulus(3, 11, 2, 0, 0, c, d, e, g, pv, pb);
        total++; if (d !== 5'd1) begin bad++; $display("FAIL midreset next_frame data: got %0d want 1", d); end
        total++; if (c !== 7) begin bad++; $display("FAIL midreset next_frame cycle: got %0d want 7", c); end
    endtask

    task automatic test_ignored_input();
        int c, g, want; logic [WIDTH-1:0] d; logic e, pv, pb;
        frameData[0] = 3; frameData[1] = 6;
        want = frameProduct(2, 3, 13);
        applyStimulus(3, 13, 2, 3, 2, c, d, e, g, pv, pb);
        total++; if (d !== WIDTH'(want)) begin bad++; $display("FAIL drain_junk data: got %0d want %0d", d, want); end
        total++; if (e !== 1'b0) begin bad++; $display("FAIL drain_junk err: got %b want 0", e); end
        total++; if (c !== 7) begin bad++; $display("FAIL drain_junk cycle: got %0d want 7", c); end
        total++; if (pb !== 1'b0) begin bad++; $display("FAIL drain_junk busy_after: got %b want 0", pb); end
    endtask

    task automatic test_back_to_back();
        int c, g, n, dg, pl, want; logic [WIDTH-1:0] d; logic e, pv, pb;
        for (int f = 0; f < 3; f++) begin
            dg = 2 + f; pl = pickPoly(dg); n = 3 + f;
            for (int k = 0; k < n; k++) frameData[k] = $urandom_range(1, (1 << dg) - 1);
            want = frameProduct(n, dg, pl);
            applyStimulus(dg, pl, n, 0, 0, c, d, e, g, pv, pb);
            total++; if (d !== WIDTH'(want)) begin bad++; $display("FAIL b2b[%0d] data: got %0d want %0d", f, d, want); end
            total++; if (c !== expectedCycle(n, dg)) begin
                bad++; $display("FAIL b2b[%0d] cycle: got %0d want %0d", f, c, expectedCycle(n, dg));
            end
        end
    endtask

    task automatic test_random();
        int c, g, n, dg, pl, want, mask; logic [WIDTH-1:0] d; logic e, pv, pb;
        for (int f = 0; f < 25; f++) begin
            dg   = $urandom_range(2, 5);
            pl   = pickPoly(dg);
            n    = $urandom_range(1, 11);
            mask = (1 << dg) - 1;
            for (int k = 0; k < n; k++)
                frameData[k] = ($urandom_range(0, 6) == 0) ? int'($urandom & 31 & ~mask) : int'($urandom & 31);
            want = frameProduct(n, dg, pl);
            applyStimulus(dg, pl, n, 0, 0, c, d, e, g, pv, pb);
            total++; if (d !== WIDTH'(want)) begin bad++; $display("FAIL rand[%0d] data: got %0d want %0d", f, d, want); end
            total++; if (e !== (n > MAX_LEN)) begin bad++; $display("FAIL rand[%0d] err: got %b want %b", f, e, n > MAX_LEN); end
            total++; if (c !== expectedCycle(n, dg)) begin
                bad++; $display("FAIL rand[%0d] cycle: got %0d want %0d", f, c, expectedCycle(n, dg));
            end
            total++; if (g !== 0) begin bad++; $display("FAIL rand[%0d] glitches: got %0d want 0", f, g); end
            total++; if ({pv, pb} !== 2'b00) begin bad++; $display("FAIL rand[%0d] after: got %b want 00", f, {pv, pb}); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_burst();
        test_single_latency();
        test_overflow();
        test_reset_mid_frame();
        test_ignored_input();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
